hazard_controller: RTL and testbench

Pipeline hazard and data-memory sequencing controller for the 5-stage RV32I core. It compares register addresses across the D/E/M/W stages and produces the forwarding selects. It also produces the stall and flush strobes for the pipeline registers. It owns the request/ready handshake to a variable-latency data memory, including a timeout-to-fault path, and keeps a saturating stall-cycle counter for performance checks.

---
 rtl/hazard_controller_if.sv | 45 ++++
 rtl/hazard_controller.sv | 119 +++++++++++
 tb/tb_hazard_controller.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/hazard_controller_if.sv
// Hazard controller signal bundle: pipeline register addresses and controls in, forwarding/stall/flush/memory handshake out.
// master drives the i_* side (pipeline), slave is the controller itself.
interface hazard_controller_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       i_rs1_d;
  logic [4:0]       i_rs2_d;
  logic [4:0]       i_rs1_e;
  logic [4:0]       i_rs2_e;
  logic [4:0]       i_rd_e;
  logic [1:0]       i_result_src_e;
  logic             i_pc_src_e;
  logic [4:0]       i_rd_m;
  logic [4:0]       i_rd_w;
  logic             i_reg_write_m;
  logic             i_reg_write_w;
  logic             i_mem_access_m;
  logic             i_dmem_ready;
  logic [1:0]       o_forward_a_e;
  logic [1:0]       o_forward_b_e;
  logic             o_stall_f;
  logic             o_stall_d;
  logic             o_stall_e;
  logic             o_stall_m;
  logic             o_flush_d;
  logic             o_flush_e;
  logic             o_flush_w;
  logic             o_dmem_req;
  logic             o_mem_fault;
  logic [CNT_W-1:0] o_stall_count;

  modport master (
    output i_rs1_d, i_rs2_d, i_rs1_e, i_rs2_e, i_rd_e, i_result_src_e, i_pc_src_e,
           i_rd_m, i_rd_w, i_reg_write_m, i_reg_write_w, i_mem_access_m, i_dmem_ready,
    input  o_forward_a_e, o_forward_b_e, o_stall_f, o_stall_d, o_stall_e, o_stall_m,
           o_flush_d, o_flush_e, o_flush_w, o_dmem_req, o_mem_fault, o_stall_count
  );

  modport slave (
    input  i_rs1_d, i_rs2_d, i_rs1_e, i_rs2_e, i_rd_e, i_result_src_e, i_pc_src_e,
           i_rd_m, i_rd_w, i_reg_write_m, i_reg_write_w, i_mem_access_m, i_dmem_ready,
    output o_forward_a_e, o_forward_b_e, o_stall_f, o_stall_d, o_stall_e, o_stall_m,
           o_flush_d, o_flush_e, o_flush_w, o_dmem_req, o_mem_fault, o_stall_count
  );
endinterface

// File: rtl/hazard_controller.sv
// RV32I hazard unit: same-cycle forwarding, load-use/branch stall-flush, data-memory wait FSM with timeout fault.
// All outputs combinational except o_mem_fault and o_stall_count; memory backpressure freezes F/D/E/M and bubbles W.
module hazard_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input logic               i_clk,
  input logic               i_rst,
  hazard_controller_if.slave hz
);
  localparam int WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WCNT_LAST = WCW'(MEM_TIMEOUT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WCW-1:0]   wcnt_q, wcnt_d;
  logic             fault_q, fault_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] fwd_a, fwd_b;
  logic       lw_stall, mem_stall, req;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_w;

  always_comb begin
    fwd_a = 2'b00;
    if (hz.i_rs1_e != 5'd0 && hz.i_reg_write_m && hz.i_rd_m == hz.i_rs1_e)
      fwd_a = 2'b10;
    else if (hz.i_rs1_e != 5'd0 && hz.i_reg_write_w && hz.i_rd_w == hz.i_rs1_e)
      fwd_a = 2'b01;
    fwd_b = 2'b00;
    if (hz.i_rs2_e != 5'd0 && hz.i_reg_write_m && hz.i_rd_m == hz.i_rs2_e)
      fwd_b = 2'b10;
    else if (hz.i_rs2_e != 5'd0 && hz.i_reg_write_w && hz.i_rd_w == hz.i_rs2_e)
      fwd_b = 2'b01;
  end

  assign lw_stall = (hz.i_result_src_e == 2'b01) && (hz.i_rd_e != 5'd0) &&
                    ((hz.i_rd_e == hz.i_rs1_d) || (hz.i_rd_e == hz.i_rs2_d));

  // wcnt_q counts completed request cycles without ready; ready in cycle MEM_TIMEOUT still completes
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    req       = 1'b0;
    mem_stall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req = hz.i_mem_access_m;
        if (hz.i_mem_access_m && !hz.i_dmem_ready) begin
          mem_stall = 1'b1;
          state_d   = ST_WAIT;
          wcnt_d    = WCW'(1);
        end
      end
      ST_WAIT: begin
        req = 1'b1;
        if (hz.i_dmem_ready) begin
          state_d = ST_IDLE;
          wcnt_d  = '0;
        end else begin
          mem_stall = 1'b1;
          if (wcnt_q == WCNT_LAST) state_d = ST_FAULT;
          else                     wcnt_d  = wcnt_q + 1'b1;
        end
      end
      ST_FAULT: mem_stall = 1'b1;
      default:  state_d   = ST_IDLE;
    endcase
  end

  assign fault_d = fault_q | (state_d == ST_FAULT);

  // A stalled branch/load-use stays in E/D and is reconsidered once memory releases
  always_comb begin
    stall_f = 1'b0; stall_d = 1'b0; stall_e = 1'b0; stall_m = 1'b0;
    flush_d = 1'b0; flush_e = 1'b0; flush_w = 1'b0;
    if (mem_stall) begin
      stall_f = 1'b1; stall_d = 1'b1; stall_e = 1'b1; stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (hz.i_pc_src_e) begin
      flush_d = 1'b1; flush_e = 1'b1;
    end else if (lw_stall) begin
      stall_f = 1'b1; stall_d = 1'b1; flush_e = 1'b1;
    end
  end

  assign cnt_d = (stall_f && cnt_q != {CNT_W{1'b1}}) ? cnt_q + 1'b1 : cnt_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.o_forward_a_e = i_rst ? 2'b00 : fwd_a;
  assign hz.o_forward_b_e = i_rst ? 2'b00 : fwd_b;
  assign hz.o_stall_f     = ~i_rst & stall_f;
  assign hz.o_stall_d     = ~i_rst & stall_d;
  assign hz.o_stall_e     = ~i_rst & stall_e;
  assign hz.o_stall_m     = ~i_rst & stall_m;
  assign hz.o_flush_d     = ~i_rst & flush_d;
  assign hz.o_flush_e     = ~i_rst & flush_e;
  assign hz.o_flush_w     = ~i_rst & flush_w;
  assign hz.o_dmem_req    = ~i_rst & req;
  assign hz.o_mem_fault   = ~i_rst & fault_q;
  assign hz.o_stall_count = i_rst ? '0 : cnt_q;
endmodule

// File: tb/tb_hazard_controller.sv
// Self-checking bench for hazard_controller; per-cycle expected outputs queued at drive time, compared mid-cycle.
module tb_hazard_controller;
  localparam int MT = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  hazard_controller_if #(.CNT_W(CW)) hz ();
  hazard_controller #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (.i_clk(clk), .i_rst(rst), .hz(hz));

  int checks = 0;
  int failures = 0;
  logic [CW-1:0] exp_cnt;
  logic [12:0] sb[$];

  wire [12:0] obs = {hz.o_forward_a_e, hz.o_forward_b_e, hz.o_stall_f, hz.o_stall_d,
                     hz.o_stall_e, hz.o_stall_m, hz.o_flush_d, hz.o_flush_e,
                     hz.o_flush_w, hz.o_dmem_req, hz.o_mem_fault};

  function automatic logic [12:0] mk(input logic [1:0] fa, input logic [1:0] fb,
                                     input logic sf, input logic sd, input logic se,
                                     input logic sm, input logic fd, input logic fe,
                                     input logic fw, input logic rq, input logic flt);
    return {fa, fb, sf, sd, se, sm, fd, fe, fw, rq, flt};
  endfunction

  logic [12:0] ZERO, LW, BR, MS, RQ, FLT;

  task automatic clear_inputs();
    hz.i_rs1_d = 0; hz.i_rs2_d = 0; hz.i_rs1_e = 0; hz.i_rs2_e = 0; hz.i_rd_e = 0;
    hz.i_result_src_e = 0; hz.i_pc_src_e = 0; hz.i_rd_m = 0; hz.i_rd_w = 0;
    hz.i_reg_write_m = 0; hz.i_reg_write_w = 0; hz.i_mem_access_m = 0; hz.i_dmem_ready = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    clear_inputs();
    exp_cnt = '0;
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_lw(input logic on);
    hz.i_result_src_e = on ? 2'b01 : 2'b00;
    hz.i_rd_e  = on ? 5'd7 : 5'd0;
    hz.i_rs2_d = on ? 5'd7 : 5'd0;
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    hz.i_rs1_e = 5; hz.i_rd_m = 5; hz.i_reg_write_m = 1;
    hz.i_mem_access_m = 1; set_lw(1'b1);
    #2;
    checks++;
    if (obs !== ZERO) begin failures++; $display("FAIL reset_outputs got=%b want=%b", obs, ZERO); end
    checks++;
    if (hz.o_stall_count !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", hz.o_stall_count); end
    @(posedge clk); #1;
    checks++;
    if (obs !== ZERO || hz.o_stall_count !== 4'd0) begin
      failures++; $display("FAIL reset_held got=%b cnt=%0d want=%b cnt=0", obs, hz.o_stall_count, ZERO);
    end
    clear_inputs();
    exp_cnt = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_forwarding();
    int rs1[5] = '{5, 5, 0, 5, 7};
    int rs2[5] = '{6, 6, 6, 6, 6};
    int rdm[5] = '{5, 5, 0, 9, 6};
    int wm[5]  = '{1, 1, 1, 0, 1};
    int rdw[5] = '{6, 5, 6, 5, 6};
    int ww[5]  = '{1, 1, 1, 1, 0};
    logic [1:0] efa[5] = '{2'b10, 2'b10, 2'b00, 2'b01, 2'b00};
    logic [1:0] efb[5] = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b10};
    logic [12:0] e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      hz.i_rs1_e = 5'(rs1[i]); hz.i_rs2_e = 5'(rs2[i]);
      hz.i_rd_m = 5'(rdm[i]); hz.i_reg_write_m = 1'(wm[i]);
      hz.i_rd_w = 5'(rdw[i]); hz.i_reg_write_w = 1'(ww[i]);
      sb.push_back(mk(efa[i], efb[i], 0, 0, 0, 0, 0, 0, 0, 0, 0));
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL forwarding[%0d] got=%b want=%b", i, obs, e); end
    end
  endtask

  task automatic test_load_use();
    int rsrc[6] = '{1, 0, 1, 0, 1, 0};
    int rde[6]  = '{7, 0, 0, 7, 3, 0};
    int rs1d[6] = '{0, 0, 0, 7, 3, 0};
    int rs2d[6] = '{7, 0, 0, 0, 0, 0};
    int lw[6]   = '{1, 0, 0, 0, 1, 0};
    logic [12:0] e;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      hz.i_result_src_e = 2'(rsrc[i]); hz.i_rd_e = 5'(rde[i]);
      hz.i_rs1_d = 5'(rs1d[i]); hz.i_rs2_d = 5'(rs2d[i]);
      sb.push_back(lw[i] != 0 ? LW : ZERO);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL load_use[%0d] got=%b want=%b", i, obs, e); end
      checks++;
      if (hz.o_stall_count !== exp_cnt) begin failures++; $display("FAIL load_use_count[%0d] got=%0d want=%0d", i, hz.o_stall_count, exp_cnt); end
      if (e[8] && exp_cnt != 4'hF) exp_cnt++;
    end
  endtask

  task automatic test_branch();
    int pc[3] = '{1, 1, 0};
    int lw[3] = '{1, 0, 0};
    logic [12:0] e;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      hz.i_pc_src_e = 1'(pc[i]);
      set_lw(1'(lw[i]));
      sb.push_back(pc[i] != 0 ? BR : ZERO);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL branch[%0d] got=%b want=%b", i, obs, e); end
      checks++;
      if (hz.o_stall_count !== exp_cnt) begin failures++; $display("FAIL branch_count[%0d] got=%0d want=%0d", i, hz.o_stall_count, exp_cnt); end
      if (e[8] && exp_cnt != 4'hF) exp_cnt++;
    end
  endtask

  task automatic test_mem_latency();
    int acc[8] = '{1, 1, 1, 1, 1, 1, 0, 0};
    int rdy[8] = '{0, 0, 1, 1, 0, 1, 1, 0};
    int pc[8]  = '{1, 1, 1, 0, 0, 0, 0, 0};
    logic [12:0] ex[8];
    logic [12:0] e;
    ex = '{MS, MS, RQ | BR, RQ, MS, RQ, ZERO, ZERO};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      hz.i_mem_access_m = 1'(acc[i]); hz.i_dmem_ready = 1'(rdy[i]); hz.i_pc_src_e = 1'(pc[i]);
      sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL mem_latency[%0d] got=%b want=%b", i, obs, e); end
      checks++;
      if (hz.o_stall_count !== exp_cnt) begin failures++; $display("FAIL mem_latency_count[%0d] got=%0d want=%0d", i, hz.o_stall_count, exp_cnt); end
      if (e[8] && exp_cnt != 4'hF) exp_cnt++;
    end
  endtask

  task automatic test_timeout();
    int acc[13] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 0, 1, 1};
    int rdy[13] = '{0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    logic [12:0] ex[13];
    logic [12:0] e;
    ex = '{MS, MS, MS, RQ, ZERO, MS, MS, MS, MS, FLT, FLT, FLT, FLT};
    do_reset();
    for (int i = 0; i < 13; i++) begin
      @(posedge clk); #1;
      hz.i_mem_access_m = 1'(acc[i]); hz.i_dmem_ready = 1'(rdy[i]);
      sb.push_back(ex[i]);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL timeout[%0d] got=%b want=%b", i, obs, e); end
      checks++;
      if (hz.o_stall_count !== exp_cnt) begin failures++; $display("FAIL timeout_count[%0d] got=%0d want=%0d", i, hz.o_stall_count, exp_cnt); end
      if (e[8] && exp_cnt != 4'hF) exp_cnt++;
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (obs !== ZERO) begin failures++; $display("FAIL fault_async_reset got=%b want=%b", obs, ZERO); end
    checks++;
    if (hz.o_stall_count !== 4'd0) begin failures++; $display("FAIL fault_reset_count got=%0d want=0", hz.o_stall_count); end
    clear_inputs();
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
    @(posedge clk); #1;
    checks++;
    if (obs !== ZERO) begin failures++; $display("FAIL fault_cleared got=%b want=%b", obs, ZERO); end
  endtask

  task automatic test_saturation();
    logic [12:0] e;
    do_reset();
    for (int i = 0; i < 23; i++) begin
      @(posedge clk); #1;
      set_lw(i < 20);
      sb.push_back(i < 20 ? LW : ZERO);
      @(negedge clk);
      e = sb.pop_front();
      checks++;
      if (obs !== e) begin failures++; $display("FAIL saturation[%0d] got=%b want=%b", i, obs, e); end
      checks++;
      if (hz.o_stall_count !== exp_cnt) begin failures++; $display("FAIL saturation_count[%0d] got=%0d want=%0d", i, hz.o_stall_count, exp_cnt); end
      if (e[8] && exp_cnt != 4'hF) exp_cnt++;
    end
    checks++;
    if (hz.o_stall_count !== 4'd15) begin failures++; $display("FAIL saturation_final got=%0d want=15", hz.o_stall_count); end
  endtask

  initial begin
    ZERO = '0;
    LW   = mk(0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0);
    BR   = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    MS   = mk(0, 0, 1, 1, 1, 1, 0, 0, 1, 1, 0);
    RQ   = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    FLT  = mk(0, 0, 1, 1, 1, 1, 0, 0, 1, 0, 1);
    exp_cnt = '0;
    clear_inputs();
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch();
    test_mem_latency();
    test_timeout();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
